// File: rtl/sram_bist_pkg.sv
// Shared types and helpers for the SRAM built-in self-test sequencer.
// Optional build macro: SRAM_BIST_ERR_LOG_EN (first-mismatch logging in sram_bist).
package sram_bist_pkg;

   localparam int ADDR_W_DEF = 15;
   localparam int DATA_W_DEF = 8;
   localparam int ERR_CNT_W  = 16;
   localparam int PACE_W     = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_WGAP  = 3'd2,
      S_READ  = 3'd3,
      S_RWAIT = 3'd4,
      S_CHECK = 3'd5,
      S_FIN   = 3'd6
   } state_e;

   // Test pattern for an address: low address bits XOR the run seed.
   // Works on 32-bit containers; callers cast the result down to DATA_W.
   function automatic logic [31:0] pat(input logic [31:0] a, input logic [31:0] s);
      return a ^ s;
   endfunction

endpackage

// File: rtl/sram_bist_pacer.sv
// Loadable down-counter that times the WGAP and RWAIT waits.
// zero is high whenever the count has reached 0; the count then stays at 0.
module sram_bist_pacer
   import sram_bist_pkg::*;
#(
   parameter int W = PACE_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count_q, count_d;

   // Next count: load wins, otherwise count down and park at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/sram_bist.sv
// SRAM BIST sequencer: writes pat(a) to every address, reads each back and
// compares, reporting pass/fail and a saturating error count.
// Optional build macro: SRAM_BIST_ERR_LOG_EN latches the first mismatch
// (address, expected, actual); without it those outputs are tied to 0.
// Handshake: the controller has no acknowledge; sram_wreq/sram_rreq are
// one-cycle pulses accepted unconditionally, paced by WR_GAP and RD_LAT.
module sram_bist
   import sram_bist_pkg::*;
#(
   parameter int          ADDR_W    = ADDR_W_DEF,
   parameter int          DATA_W    = DATA_W_DEF,
   parameter int unsigned LAST_ADDR = (1 << ADDR_W) - 1,
   parameter int          WR_GAP    = 2,
   parameter int          RD_LAT    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATA_W-1:0]    seed,
   output logic                 sram_wreq,
   output logic [ADDR_W-1:0]    sram_waddr,
   output logic [DATA_W-1:0]    sram_wdata,
   output logic                 sram_rreq,
   output logic [ADDR_W-1:0]    sram_raddr,
   input  logic [DATA_W-1:0]    sram_rdata,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [ADDR_W-1:0]    err_addr,
   output logic [DATA_W-1:0]    err_exp,
   output logic [DATA_W-1:0]    err_act
);

   localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(LAST_ADDR);
   // A gap/latency of 1 skips the wait state entirely.
   localparam logic [PACE_W-1:0] WGAP_LOAD = (WR_GAP >= 2) ? PACE_W'(WR_GAP - 2) : '0;
   localparam logic [PACE_W-1:0] RLAT_LOAD = (RD_LAT >= 2) ? PACE_W'(RD_LAT - 2) : '0;

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]      seed_q, seed_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic                   pass_q, pass_d;
   logic [ADDR_W-1:0]      waddr_q, raddr_q;
   logic [DATA_W-1:0]      wdata_q;
   logic [DATA_W-1:0]      exp_data;
   logic                   mismatch;
   logic                   last_addr;
   logic                   pace_load;
   logic [PACE_W-1:0]      pace_val;
   logic                   pace_zero;

   assign exp_data  = DATA_W'(pat(32'(addr_q), 32'(seed_q)));
   assign last_addr = (addr_q == LAST_A);

   sram_bist_pacer #(.W(PACE_W)) u_pacer (
      .clk      (clk),
      .rst      (rst),
      .load     (pace_load),
      .load_val (pace_val),
      .zero     (pace_zero)
   );

   // Next-state, address walk, error counting and request decode.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      seed_d    = seed_q;
      err_cnt_d = err_cnt_q;
      pass_d    = pass_q;
      pace_load = 1'b0;
      pace_val  = '0;
      sram_wreq = 1'b0;
      sram_rreq = 1'b0;
      done      = 1'b0;
      mismatch  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               seed_d    = seed;
               err_cnt_d = '0;
               pass_d    = 1'b0;
               addr_d    = '0;
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            sram_wreq = 1'b1;
            if (WR_GAP >= 2) begin
               pace_load = 1'b1;
               pace_val  = WGAP_LOAD;
               state_d   = S_WGAP;
            end else if (last_addr) begin
               addr_d  = '0;
               state_d = S_READ;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = S_WRITE;
            end
         end
         S_WGAP: begin
            if (pace_zero) begin
               if (last_addr) begin
                  addr_d  = '0;
                  state_d = S_READ;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = S_WRITE;
               end
            end
         end
         S_READ: begin
            sram_rreq = 1'b1;
            if (RD_LAT >= 2) begin
               pace_load = 1'b1;
               pace_val  = RLAT_LOAD;
               state_d   = S_RWAIT;
            end else begin
               state_d = S_CHECK;
            end
         end
         S_RWAIT: begin
            if (pace_zero) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            mismatch = (sram_rdata != exp_data);
            if (mismatch && (err_cnt_q != '1)) begin
               err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            if (last_addr) begin
               // pass is settled on entry to FIN so it is valid in the done cycle.
               pass_d  = (err_cnt_d == '0);
               state_d = S_FIN;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = S_READ;
            end
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Address/data outputs follow the live request and otherwise hold.
   always_comb begin
      sram_waddr = sram_wreq ? addr_q   : waddr_q;
      sram_wdata = sram_wreq ? exp_data : wdata_q;
      sram_raddr = sram_rreq ? addr_q   : raddr_q;
   end

   // Sequencer state and held output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         seed_q    <= '0;
         err_cnt_q <= '0;
         pass_q    <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         raddr_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         seed_q    <= seed_d;
         err_cnt_q <= err_cnt_d;
         pass_q    <= pass_d;
         waddr_q   <= sram_waddr;
         wdata_q   <= sram_wdata;
         raddr_q   <= sram_raddr;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign pass    = pass_q;
   assign err_cnt = err_cnt_q;

`ifdef SRAM_BIST_ERR_LOG_EN
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic [DATA_W-1:0] err_exp_q, err_exp_d;
   logic [DATA_W-1:0] err_act_q, err_act_d;

   // First-mismatch log: cleared on accepted start, captured while the count is still 0.
   always_comb begin
      err_addr_d = err_addr_q;
      err_exp_d  = err_exp_q;
      err_act_d  = err_act_q;
      if ((state_q == S_IDLE) && start) begin
         err_addr_d = '0;
         err_exp_d  = '0;
         err_act_d  = '0;
      end else if (mismatch && (err_cnt_q == '0)) begin
         err_addr_d = addr_q;
         err_exp_d  = exp_data;
         err_act_d  = sram_rdata;
      end
   end

   // Error log registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_addr_q <= '0;
         err_exp_q  <= '0;
         err_act_q  <= '0;
      end else begin
         err_addr_q <= err_addr_d;
         err_exp_q  <= err_exp_d;
         err_act_q  <= err_act_d;
      end
   end

   assign err_addr = err_addr_q;
   assign err_exp  = err_exp_q;
   assign err_act  = err_act_q;
`else
   assign err_addr = '0;
   assign err_exp  = '0;
   assign err_act  = '0;
`endif

endmodule

// File: tb/tb_sram_bist.sv
// Directed bench for sram_bist with LAST_ADDR=7, WR_GAP=2, RD_LAT=2 and an
// ideal two-cycle-latency SRAM model with an optional stuck-at-0 on bit 3.
module tb_sram_bist;
   import sram_bist_pkg::*;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 8;
   localparam int QW     = ADDR_W + DATA_W;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [DATA_W-1:0]    seed;
   logic                 sram_wreq;
   logic [ADDR_W-1:0]    sram_waddr;
   logic [DATA_W-1:0]    sram_wdata;
   logic                 sram_rreq;
   logic [ADDR_W-1:0]    sram_raddr;
   logic [DATA_W-1:0]    sram_rdata;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [ERR_CNT_W-1:0] err_cnt;
   logic [ADDR_W-1:0]    err_addr;
   logic [DATA_W-1:0]    err_exp;
   logic [DATA_W-1:0]    err_act;

   int total = 0;
   int bad   = 0;

   logic [QW-1:0] exp_q[$];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   sram_bist #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .LAST_ADDR (7),
      .WR_GAP    (2),
      .RD_LAT    (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .seed       (seed),
      .sram_wreq  (sram_wreq),
      .sram_waddr (sram_waddr),
      .sram_wdata (sram_wdata),
      .sram_rreq  (sram_rreq),
      .sram_raddr (sram_raddr),
      .sram_rdata (sram_rdata),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_cnt    (err_cnt),
      .err_addr   (err_addr),
      .err_exp    (err_exp),
      .err_act    (err_act)
   );

   // ---------------- SRAM model ----------------
   logic [DATA_W-1:0] mem [0:7];
   logic [DATA_W-1:0] rd_p1 = '0;
   logic [DATA_W-1:0] rd_p2 = '0;
   logic              stuck = 1'b0;

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
   end

   always @(posedge clk) begin
      if (sram_wreq) mem[sram_waddr[2:0]] <= sram_wdata;
      if (sram_rreq) rd_p1 <= mem[sram_raddr[2:0]];
      rd_p2 <= rd_p1;
   end

   assign sram_rdata = stuck ? (rd_p2 & 8'hF7) : rd_p2;

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_writes(input logic [DATA_W-1:0] s, input int n);
      for (int a = 0; a < n; a++) begin
         logic [DATA_W-1:0] d;
         d = DATA_W'(a) ^ s;
         exp_q.push_back({ADDR_W'(a), d});
      end
   endtask

   // Every write request is checked against the expected queue.
   always @(negedge clk) begin
      if (sram_wreq && sram_rreq) check("wreq_rreq_overlap", 32'd1, 32'd0);
      if (sram_wreq) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(sram_waddr), 32'hFFFF_FFFF);
         end else begin
            logic [QW-1:0] e;
            e = exp_q.pop_front();
            check("write_addr", 32'(sram_waddr), 32'(e[QW-1:DATA_W]));
            check("write_data", 32'(sram_wdata), 32'(e[DATA_W-1:0]));
         end
      end
   end

   // ---------------- driver ----------------
   // Caller drives start at a negedge; iteration i observes cycle t+i,
   // where t is the edge that sampled start.
   task automatic run_test(input int pulse_k, output int done_k, output int first_w,
                           output logic pass1);
      done_k  = -1;
      first_w = -1;
      pass1   = 1'bx;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (i == 1) pass1 = pass;
         if (sram_wreq && first_w < 0) first_w = i;
         start = (i == pulse_k);
         if (done) begin
            done_k = i;
            break;
         end
      end
      start = 1'b0;
   endtask

   int   dk, fw, wr_seen;
   logic p1;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      seed  = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_wreq",    32'(sram_wreq),  32'd0);
      check("rst_rreq",    32'(sram_rreq),  32'd0);
      check("rst_busy",    32'(busy),       32'd0);
      check("rst_done",    32'(done),       32'd0);
      check("rst_pass",    32'(pass),       32'd0);
      check("rst_err_cnt", 32'(err_cnt),    32'd0);
      check("rst_waddr",   32'(sram_waddr), 32'd0);
      check("rst_wdata",   32'(sram_wdata), 32'd0);
      check("rst_raddr",   32'(sram_raddr), 32'd0);
      check("rst_err_log", 32'({err_addr, err_exp, err_act}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Clean pass; start held into the FIN cycle must be ignored
      push_writes(8'hA5, 8);
      seed  = 8'hA5;
      start = 1'b1;
      run_test(0, dk, fw, p1);
      check("clean_first_wreq", 32'(fw), 32'd1);
      check("clean_done_time", 32'(dk), 32'd41);
      check("clean_pass", 32'(pass), 32'd1);
      check("clean_err_cnt", 32'(err_cnt), 32'd0);
      check("clean_busy_at_done", 32'(busy), 32'd1);
      check("clean_raddr_hold", 32'(sram_raddr), 32'd7);
      check("clean_waddr_hold", 32'(sram_waddr), 32'd7);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("fin_start_busy", 32'(busy), 32'd0);
      check("fin_start_wreq", 32'(sram_wreq), 32'd0);
      check("clean_pass_hold", 32'(pass), 32'd1);
      @(negedge clk);
      check("fin_start_still_idle", 32'(busy), 32'd0);

      // Stuck bit 3 low
      stuck = 1'b1;
      push_writes(8'h08, 8);
      seed  = 8'h08;
      start = 1'b1;
      run_test(0, dk, fw, p1);
      check("stuck_pass_cleared", 32'(p1), 32'd0);
      check("stuck_done_time", 32'(dk), 32'd41);
      check("stuck_err_cnt", 32'(err_cnt), 32'd8);
      check("stuck_pass", 32'(pass), 32'd0);
`ifdef SRAM_BIST_ERR_LOG_EN
      check("stuck_err_addr", 32'(err_addr), 32'd0);
      check("stuck_err_exp",  32'(err_exp),  32'h08);
      check("stuck_err_act",  32'(err_act),  32'h00);
`else
      check("stuck_err_addr", 32'(err_addr), 32'd0);
      check("stuck_err_exp",  32'(err_exp),  32'd0);
      check("stuck_err_act",  32'(err_act),  32'd0);
`endif
      stuck = 1'b0;
      @(negedge clk);

      // Start while busy (mid-read) is ignored
      push_writes(8'h3C, 8);
      seed  = 8'h3C;
      start = 1'b1;
      run_test(22, dk, fw, p1);
      check("busy_start_done_time", 32'(dk), 32'd41);
      check("busy_start_pass", 32'(pass), 32'd1);
      check("busy_start_err_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk);
      check("busy_start_idle", 32'(busy), 32'd0);

      // Reset after the third write request
      push_writes(8'h11, 3);
      seed    = 8'h11;
      start   = 1'b1;
      wr_seen = 0;
      for (int i = 0; i < 20 && wr_seen < 3; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (sram_wreq) wr_seen++;
      end
      check("rstmid_writes_seen", 32'(wr_seen), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_wreq", 32'(sram_wreq), 32'd0);
      check("rstmid_rreq", 32'(sram_rreq), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_pass", 32'(pass), 32'd0);
      check("rstmid_queue_empty", 32'(exp_q.size()), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      push_writes(8'h5A, 8);
      seed  = 8'h5A;
      start = 1'b1;
      run_test(0, dk, fw, p1);
      check("restart_first_wreq", 32'(fw), 32'd1);
      check("restart_done_time", 32'(dk), 32'd41);
      check("restart_pass", 32'(pass), 32'd1);

      // Back-to-back: start in the cycle right after done
      @(negedge clk);
      push_writes(8'hC3, 8);
      seed  = 8'hC3;
      start = 1'b1;
      run_test(0, dk, fw, p1);
      check("b2b_pass_cleared", 32'(p1), 32'd0);
      check("b2b_first_wreq", 32'(fw), 32'd1);
      check("b2b_done_time", 32'(dk), 32'd41);
      check("b2b_pass", 32'(pass), 32'd1);
      check("b2b_err_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_bist.md
# sram_bist

Built-in self-test sequencer that sits directly upstream of the SRAM controller and drives its write/read request interface. On `start` it writes a seeded pattern to every address from 0 to `LAST_ADDR`, then reads each address back and compares. It reports pass/fail, an error count and, optionally, the first failing location. Because the controller has no acknowledge, the sequencer paces its own requests using fixed, parameterised gaps.

## Interface
- `ADDR_W`, 15: SRAM address width.
- `DATA_W`, 8: SRAM data width.
- `LAST_ADDR`, 2^ADDR_W-1: highest address tested.
- `WR_GAP`, 2: cycles from one `sram_wreq` pulse to the next; legal range is 1 or more.
- `RD_LAT`, 2: cycles from a `sram_rreq` pulse to `sram_rdata` being valid; legal range is 1 or more.
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a test; sampled only when not busy.
- `seed`, in, DATA_W: pattern seed, captured on accepted `start`.
- `sram_wreq`, out, 1: one-cycle write request.
- `sram_waddr`, out, ADDR_W: write address.
- `sram_wdata`, out, DATA_W: write data.
- `sram_rreq`, out, 1: one-cycle read request.
- `sram_raddr`, out, ADDR_W: read address.
- `sram_rdata`, in, DATA_W: read data from the controller.
- `busy`, out, 1: test in progress.
- `done`, out, 1: one-cycle pulse at test end.
- `pass`, out, 1: set at `done` when `err_cnt`==0; held until the next accepted `start`.
- `err_cnt`, out, 16: count of mismatches; saturates at 0xFFFF.
- `err_addr`, out, ADDR_W: address of the first mismatch (see Configuration).
- `err_exp`, out, DATA_W: expected data at the first mismatch (see Configuration).
- `err_act`, out, DATA_W: actual data at the first mismatch (see Configuration).

## Operation
- **States:** IDLE, WRITE, WGAP, READ, RWAIT, CHECK, FIN.
- **Pattern:** `pat(a) = a[DATA_W-1:0] ^ seed_q`.
- **IDLE:** when `start`=1, capture the seed, clear `err_cnt`, `pass` and the error log, set address 0, go to WRITE.
- **WRITE:** assert `sram_wreq` with `sram_waddr`=addr and `sram_wdata`=pat(addr), then go to WGAP.
- **WGAP:** wait `WR_GAP-1` cycles.
  - If addr==`LAST_ADDR`: set addr=0, go to READ.
  - Otherwise: increment addr, go to WRITE.
- **READ:** assert `sram_rreq` with `sram_raddr`=addr, go to RWAIT.
- **RWAIT:** wait `RD_LAT-1` cycles, then go to CHECK.
- **CHECK:** compare `sram_rdata` with pat(addr).
  - On mismatch: increment `err_cnt` (saturating); log the first mismatch.
  - Then, if addr==`LAST_ADDR`, go to FIN; otherwise increment addr and go to READ.
- **FIN:** pulse `done`, set `pass`, return to IDLE.
- `sram_wreq` and `sram_rreq` are never asserted in the same cycle.
- Address outputs hold their last value while the corresponding request is low.
- `start` while busy is ignored.
- `start` in the FIN cycle is ignored; it is accepted from the following cycle.
- `rst` at any cycle returns the block to IDLE at that edge. No request is driven in the following cycle.

## Timing
- **Reset values:** all outputs 0.
- `start` sampled at edge t → first `sram_wreq` high in cycle t+1.
- Write phase lasts (`LAST_ADDR`+1)·`WR_GAP` cycles.
- A read is issued in cycle r; data is sampled in cycle r+`RD_LAT`; the next `sram_rreq` is in cycle r+`RD_LAT`+1.
- `done` is high in cycle t+1+(`LAST_ADDR`+1)·(`WR_GAP`+`RD_LAT`+1).
- `busy` is high from t+1 through the `done` cycle inclusive.

## Configuration
- **`SRAM_BIST_ERR_LOG_EN` defined:** `err_addr`, `err_exp` and `err_act` latch the first mismatch of a run and hold it until the next accepted `start`.
- **Undefined:** the three outputs are tied to 0 and the logging registers are not built. `err_cnt` and `pass` are unaffected.

## Structure
- **Package `sram_bist_pkg`:** state enum, `ADDR_W`/`DATA_W` defaults, `ERR_CNT_W`=16, and the `pat()` function.
- **Sub-module `sram_bist_pacer`:** loadable down-counter with a `zero` flag, used for both the WGAP and RWAIT waits.

## Test plan
All scenarios use `LAST_ADDR`=7, `WR_GAP`=2, `RD_LAT`=2 and an ideal SRAM model.
- **Clean pass:** `seed`=0xA5, `start` at t → 8 writes at addresses 0..7 with data 0xA5^addr; `done` at t+41; `pass`=1; `err_cnt`=0.
- **Stuck bit:** model forces `rdata[3]`=0, `seed`=0x08 → `err_cnt`=8, `pass`=0, `err_addr`=0, `err_exp`=0x08, `err_act`=0x00.
- **Start while busy:** `start` pulsed mid-read-phase → no effect; `done` is still at t+41.
- **Reset mid-write:** `rst` after the 3rd `sram_wreq` → `sram_wreq`/`busy` are 0 the following cycle; a new `start` restarts cleanly from address 0.
- **Back-to-back runs:** `start` in the cycle after `done` is accepted; `pass` clears and the second run completes with `pass`=1.
- **Macro undefined, stuck-bit stimulus:** `err_cnt`=8; `err_addr`, `err_exp` and `err_act` remain 0.
